// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous memory between the core and an aux master (loader/DMA).
// Latency: grant is combinational (0 cycles), read data returns to the owner 1 cycle after grant.
// Backpressure: a requester holds req/payload until gnt; aux locks are bounded by MAX_LOCK core wait cycles.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic                clk,
    input  logic                rst,
    // core port
    input  logic                c_req,
    input  logic                c_we,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_wstrb,
    output logic                c_gnt,
    output logic                c_rvalid,
    output logic [DATA_W-1:0]   c_rdata,
    // auxiliary port
    input  logic                a_req,
    input  logic                a_we,
    input  logic                a_lock,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    input  logic [DATA_W/8-1:0] a_wstrb,
    output logic                a_gnt,
    output logic                a_rvalid,
    output logic [DATA_W-1:0]   a_rdata,
    // memory macro
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_BREAK  = 2'd2
    } state_t;

    // MAX_LOCK is limited to 1..255, so an 8-bit wait counter always suffices
    localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

    state_t     state, state_nxt;
    logic       last_aux, last_aux_nxt;   // 1: aux was granted most recently
    logic [7:0] wait_cnt, wait_cnt_nxt;

    // Grant decision: round-robin when idle, aux-only while locked, core-only while breaking a lock
    always_comb begin
        c_gnt = 1'b0;
        a_gnt = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (c_req && a_req) begin
                        c_gnt = last_aux;
                        a_gnt = !last_aux;
                    end else begin
                        c_gnt = c_req;
                        a_gnt = a_req;
                    end
                end
                ST_LOCKED: a_gnt = a_req;
                ST_BREAK:  c_gnt = c_req;
                default: begin
                    c_gnt = 1'b0;
                    a_gnt = 1'b0;
                end
            endcase
        end
    end

    // Next state, starvation counter and round-robin pointer
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        last_aux_nxt = last_aux;

        case (state)
            ST_IDLE: begin
                if (a_gnt && a_lock)
                    state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                // a final aux beat wins over the guard firing in the same cycle
                if (a_gnt && !a_lock)
                    state_nxt = ST_IDLE;
                else if (wait_cnt == MAX_CNT)
                    state_nxt = ST_BREAK;
            end
            ST_BREAK: begin
                if (c_gnt || !c_req)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // counter only runs while the core is actually stuck behind the lock
        if (state == ST_LOCKED && state_nxt == ST_LOCKED && c_req)
            wait_cnt_nxt = (wait_cnt == MAX_CNT) ? wait_cnt : wait_cnt + 8'd1;

        if (c_gnt)
            last_aux_nxt = 1'b0;
        else if (a_gnt)
            last_aux_nxt = 1'b1;
    end

    // State registers; reset leaves aux as last owner so the core wins the first contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            last_aux <= 1'b1;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last_aux <= last_aux_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Memory request mux; idle cycles present the core payload with enables and strobes low
    always_comb begin
        mem_en    = c_gnt | a_gnt;
        mem_we    = a_gnt ? a_we : (c_gnt & c_we);
        mem_addr  = a_gnt ? a_addr  : c_addr;
        mem_wdata = a_gnt ? a_wdata : c_wdata;
        mem_wstrb = a_gnt ? a_wstrb : (c_gnt ? c_wstrb : '0);
    end

    // Read-valid tracking: the owner of a granted read sees data the following cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_rvalid <= 1'b0;
            a_rvalid <= 1'b0;
        end else begin
            c_rvalid <= c_gnt & ~c_we;
            a_rvalid <= a_gnt & ~a_we;
        end
    end

    // Read data is shared; only the port flagged by rvalid should consume it
    assign c_rdata = mem_rdata;
    assign a_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_wstrb;
    logic        c_gnt, c_rvalid;
    logic [31:0] c_rdata;
    logic        a_req, a_we, a_lock;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_wstrb;
    logic        a_gnt, a_rvalid;
    logic [31:0] a_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_wstrb(a_wstrb), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: word at addr X initialised to 0x10000000+X, except 0x100 = 0xDEADBEEF
    logic [31:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | (i << 2);
        mem[64] = 32'hDEAD_BEEF;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[9:2]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        c_req, c_we;
        logic [31:0] c_addr, c_wdata;
        logic [3:0]  c_wstrb;
        logic        a_req, a_we, a_lock;
        logic [31:0] a_addr, a_wdata;
        logic        e_cg, e_ag, e_crv, e_arv;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t v(input logic cr, input logic cw, input logic [31:0] ca,
                               input logic [31:0] cd, input logic [3:0] cs,
                               input logic ar, input logic aw, input logic al,
                               input logic [31:0] aa, input logic [31:0] ad,
                               input logic ecg, input logic eag, input logic ecrv,
                               input logic earv, input logic [31:0] ed);
        vec_t r;
        r.c_req = cr; r.c_we = cw; r.c_addr = ca; r.c_wdata = cd; r.c_wstrb = cs;
        r.a_req = ar; r.a_we = aw; r.a_lock = al; r.a_addr = aa; r.a_wdata = ad;
        r.e_cg = ecg; r.e_ag = eag; r.e_crv = ecrv; r.e_arv = earv; r.e_rdata = ed;
        return r;
    endfunction

    task automatic drive(input vec_t r);
        c_req = r.c_req; c_we = r.c_we; c_addr = r.c_addr; c_wdata = r.c_wdata; c_wstrb = r.c_wstrb;
        a_req = r.a_req; a_we = r.a_we; a_lock = r.a_lock; a_addr = r.a_addr; a_wdata = r.a_wdata;
        a_wstrb = 4'hF;
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_wstrb = 0;
        a_req = 0; a_we = 0; a_lock = 0; a_addr = 0; a_wdata = 0; a_wstrb = 4'hF;
    endtask

    vec_t tbl [27];
    logic [31:0] e_addr;
    logic        e_we;
    int          k;
    bit          found;

    initial begin
        // Each row is one cycle; rvalid/rdata expectations refer to the previous row's grant
        //            c_req we addr          wdata          strb  a_req we lk addr          wdata          cg ag crv arv rdata
        tbl[0]  = v(1, 0, 32'h100, 32'h0,         4'h0, 0, 0, 0, 32'h0,   32'h0,         1, 0, 0, 0, 32'h0);
        tbl[1]  = v(0, 0, 32'h0,   32'h0,         4'h0, 1, 0, 0, 32'h10C, 32'h0,         0, 1, 1, 0, 32'hDEADBEEF);
        tbl[2]  = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 0, 0, 32'h108, 32'h0,         1, 0, 0, 1, 32'h1000010C);
        tbl[3]  = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 0, 0, 32'h108, 32'h0,         0, 1, 1, 0, 32'h10000104);
        tbl[4]  = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 0, 0, 32'h108, 32'h0,         1, 0, 0, 1, 32'h10000108);
        tbl[5]  = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 0, 0, 32'h108, 32'h0,         0, 1, 1, 0, 32'h10000104);
        tbl[6]  = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 0, 0, 32'h108, 32'h0,         1, 0, 0, 1, 32'h10000108);
        tbl[7]  = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 0, 0, 32'h108, 32'h0,         0, 1, 1, 0, 32'h10000104);
        tbl[8]  = v(1, 0, 32'h110, 32'h0,         4'h0, 0, 0, 0, 32'h0,   32'h0,         1, 0, 0, 1, 32'h10000108);
        // locked 4-beat aux write burst with the core waiting
        tbl[9]  = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 1, 1, 32'h200, 32'hCAFE0200,  0, 1, 1, 0, 32'h10000110);
        tbl[10] = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 1, 1, 32'h204, 32'hCAFE0204,  0, 1, 0, 0, 32'h0);
        tbl[11] = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 1, 1, 32'h208, 32'hCAFE0208,  0, 1, 0, 0, 32'h0);
        tbl[12] = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 1, 0, 32'h20C, 32'hCAFE020C,  0, 1, 0, 0, 32'h0);
        tbl[13] = v(1, 0, 32'h104, 32'h0,         4'h0, 0, 0, 0, 32'h0,   32'h0,         1, 0, 0, 0, 32'h0);
        tbl[14] = v(0, 0, 32'h0,   32'h0,         4'h0, 1, 0, 0, 32'h204, 32'h0,         0, 1, 1, 0, 32'h10000104);
        // core partial-strobe write then readback
        tbl[15] = v(1, 1, 32'h300, 32'h11223344,  4'h3, 0, 0, 0, 32'h0,   32'h0,         1, 0, 0, 1, 32'hCAFE0204);
        tbl[16] = v(1, 0, 32'h300, 32'h0,         4'h0, 0, 0, 0, 32'h0,   32'h0,         1, 0, 0, 0, 32'h0);
        tbl[17] = v(0, 0, 32'h0,   32'h0,         4'h0, 0, 0, 0, 32'h0,   32'h0,         0, 0, 1, 0, 32'h10003344);
        // lock ends on the very cycle the starvation counter reaches MAX_LOCK
        tbl[18] = v(0, 0, 32'h0,   32'h0,         4'h0, 1, 1, 1, 32'h210, 32'h0,         0, 1, 0, 0, 32'h0);
        tbl[19] = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 1, 1, 32'h214, 32'h0,         0, 1, 0, 0, 32'h0);
        tbl[20] = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 1, 1, 32'h218, 32'h0,         0, 1, 0, 0, 32'h0);
        tbl[21] = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 1, 1, 32'h21C, 32'h0,         0, 1, 0, 0, 32'h0);
        tbl[22] = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 1, 1, 32'h220, 32'h0,         0, 1, 0, 0, 32'h0);
        tbl[23] = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 1, 0, 32'h224, 32'h0,         0, 1, 0, 0, 32'h0);
        tbl[24] = v(1, 0, 32'h104, 32'h0,         4'h0, 1, 0, 0, 32'h200, 32'h0,         1, 0, 0, 0, 32'h0);
        tbl[25] = v(0, 0, 32'h0,   32'h0,         4'h0, 1, 0, 0, 32'h200, 32'h0,         0, 1, 1, 0, 32'h10000104);
        tbl[26] = v(0, 0, 32'h0,   32'h0,         4'h0, 0, 0, 0, 32'h0,   32'h0,         0, 0, 0, 1, 32'hCAFE0200);

        // Reset phase: both requesting, nothing may be granted
        rst = 1'b1;
        idle_inputs();
        c_req = 1; a_req = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset c_gnt", {31'b0, c_gnt}, 0);
        chk("reset a_gnt", {31'b0, a_gnt}, 0);
        chk("reset mem_en", {31'b0, mem_en}, 0);
        chk("reset c_rvalid", {31'b0, c_rvalid}, 0);
        chk("reset a_rvalid", {31'b0, a_rvalid}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            @(negedge clk);
            e_addr = tbl[i].e_ag ? tbl[i].a_addr : tbl[i].c_addr;
            e_we   = tbl[i].e_ag ? tbl[i].a_we : (tbl[i].e_cg & tbl[i].c_we);
            chk($sformatf("row%0d c_gnt", i), {31'b0, c_gnt}, {31'b0, tbl[i].e_cg});
            chk($sformatf("row%0d a_gnt", i), {31'b0, a_gnt}, {31'b0, tbl[i].e_ag});
            chk($sformatf("row%0d mem_en", i), {31'b0, mem_en}, {31'b0, tbl[i].e_cg | tbl[i].e_ag});
            chk($sformatf("row%0d mem_we", i), {31'b0, mem_we}, {31'b0, e_we});
            chk($sformatf("row%0d mem_addr", i), mem_addr, e_addr);
            chk($sformatf("row%0d c_rvalid", i), {31'b0, c_rvalid}, {31'b0, tbl[i].e_crv});
            chk($sformatf("row%0d a_rvalid", i), {31'b0, a_rvalid}, {31'b0, tbl[i].e_arv});
            if (tbl[i].e_crv) chk($sformatf("row%0d c_rdata", i), c_rdata, tbl[i].e_rdata);
            if (tbl[i].e_arv) chk($sformatf("row%0d a_rdata", i), a_rdata, tbl[i].e_rdata);
        end

        // Starvation guard: aux keeps the lock forever, core must get in after MAX_LOCK+1 cycles
        @(posedge clk); #1;
        idle_inputs();
        a_req = 1; a_we = 1; a_lock = 1; a_addr = 32'h240; a_wdata = 32'h5555AAAA;
        @(negedge clk);
        chk("starve lock grant", {31'b0, a_gnt}, 1);
        @(posedge clk); #1;
        c_req = 1; c_we = 0; c_addr = 32'h104;
        k = 0;
        found = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (c_gnt) begin
                found = 1;
                break;
            end
            chk($sformatf("starve a_gnt k%0d", k), {31'b0, a_gnt}, 1);
            @(posedge clk); #1;
            k++;
        end
        chk("starve grant seen", {31'b0, found}, 1);
        chk("starve latency", k, 5);
        chk("starve break a_gnt", {31'b0, a_gnt}, 0);
        @(posedge clk); #1;
        c_req = 0;
        @(negedge clk);
        chk("relock a_gnt", {31'b0, a_gnt}, 1);
        chk("break read c_rvalid", {31'b0, c_rvalid}, 1);
        chk("break read c_rdata", c_rdata, 32'h10000104);
        @(posedge clk); #1;
        c_req = 1;
        @(negedge clk);
        chk("relocked c_gnt", {31'b0, c_gnt}, 0);
        chk("relocked a_gnt", {31'b0, a_gnt}, 1);
        @(posedge clk); #1;
        a_lock = 0;
        @(negedge clk);
        chk("unlock a_gnt", {31'b0, a_gnt}, 1);
        @(posedge clk); #1;
        a_req = 0;
        @(negedge clk);
        chk("post-unlock c_gnt", {31'b0, c_gnt}, 1);

        // Reset right after a core read grant: no rvalid, no grants, core first afterwards
        @(posedge clk); #1;
        idle_inputs();
        c_req = 1; c_addr = 32'h108;
        @(negedge clk);
        chk("pre-reset c_gnt", {31'b0, c_gnt}, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        a_req = 1; a_addr = 32'h10C;
        @(negedge clk);
        chk("mid-reset c_rvalid", {31'b0, c_rvalid}, 0);
        chk("mid-reset c_gnt", {31'b0, c_gnt}, 0);
        chk("mid-reset a_gnt", {31'b0, a_gnt}, 0);
        chk("mid-reset mem_en", {31'b0, mem_en}, 0);
        @(posedge clk);
        @(negedge clk);
        chk("mid-reset c_rvalid 2", {31'b0, c_rvalid}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset c_gnt", {31'b0, c_gnt}, 1);
        chk("post-reset a_gnt", {31'b0, a_gnt}, 0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("post-reset c_rvalid", {31'b0, c_rvalid}, 1);
        chk("post-reset c_rdata", c_rdata, 32'h10000108);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
